// File: rtl/mcpu_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory port, redirect input and decode-side handshake.
// master = fetch queue, slave = memory/consumer side.
interface mcpu_fetch_queue_if #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [WORD_SIZE-1:0]  imem_rdata;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [WORD_SIZE-1:0]  instr_data;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc, occupancy,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc, occupancy,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/mcpu_fetch_queue.sv
// Instruction prefetch queue: streams sequential words into an address-tagged FIFO, flushes on redirect.
// Define MCPU_FETCH_BYPASS_EN to present a response straight to the consumer when the FIFO is empty.
module mcpu_fetch_queue #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                clk,
  input  logic                reset,
  mcpu_fetch_queue_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_tag;
  logic                  inflight;
  logic [WORD_SIZE-1:0]  fifo_data [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc   [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  logic                  resp_valid;
  logic                  bypass_hit;
  logic                  pop;
  logic                  pop_fifo;
  logic                  push;
  logic [CW:0]           credit_use;

  // A response is squashed when a redirect or reset lands in the same cycle.
  always_comb begin
    resp_valid = inflight & ~bus.redirect_valid & ~reset;
`ifdef MCPU_FETCH_BYPASS_EN
    bypass_hit = resp_valid & (count == '0);
`else
    bypass_hit = 1'b0;
`endif
    bus.instr_valid = (count != '0) | bypass_hit;
    bus.instr_data  = bypass_hit ? bus.imem_rdata : fifo_data[rd_ptr];
    bus.instr_pc    = bypass_hit ? inflight_tag   : fifo_pc[rd_ptr];
    bus.occupancy   = count;

    pop      = bus.instr_valid & bus.instr_ready;
    pop_fifo = pop & ~bypass_hit;
    push     = resp_valid & ~(bypass_hit & bus.instr_ready);

    // Slots already owned (stored + in flight) after this cycle's pop must leave room for a new word.
    credit_use   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    bus.imem_req = ~reset & ~bus.redirect_valid & (credit_use < (CW+1)'(DEPTH));
    bus.imem_addr = fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc     <= '0;
      inflight     <= 1'b0;
      inflight_tag <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= bus.imem_req;
      if (bus.imem_req) begin
        fetch_pc     <= fetch_pc + ADDR_WIDTH'(1);
        inflight_tag <= fetch_pc;
      end
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop_fifo)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop_fifo};
    end
  end

  // Storage needs no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]   <= inflight_tag;
    end
  end
endmodule

// File: tb/tb_mcpu_fetch_queue.sv
// Directed bench for mcpu_fetch_queue (default build, no bypass): vector table plus redirect/reset sequences.
module tb_mcpu_fetch_queue;
  logic clk = 1'b0;
  logic reset;
  int   total_checks  = 0;
  int   passed_checks = 0;

  always #5 clk = ~clk;

  mcpu_fetch_queue_if #(.WORD_SIZE(16), .ADDR_WIDTH(8), .DEPTH(4)) bus ();

  mcpu_fetch_queue #(.WORD_SIZE(16), .ADDR_WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       redir;
    logic [7:0] rpc;
    logic       req;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] pc;
    logic [2:0] occ;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return 16'h9001 + {8'h00, a};
  endfunction

  // Instruction memory: answers every request exactly one cycle later.
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : 16'hDEAD;

  function automatic vec_t row(input logic rst, rdy, redir, input logic [7:0] rpc,
                               input logic req, input logic [7:0] addr,
                               input logic valid, input logic [7:0] pc, input logic [2:0] occ);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.occ = occ;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected)
      passed_checks++;
    else
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  task automatic apply_stimulus(input logic rst, rdy, redir, input logic [7:0] rpc);
    @(negedge clk);
    reset              = rst;
    bus.instr_ready    = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
  endtask

  task automatic expect_req(input string tag, input logic req, input logic [7:0] addr);
    check_output({tag, ".imem_req"}, 32'(bus.imem_req), 32'(req));
    if (req)
      check_output({tag, ".imem_addr"}, 32'(bus.imem_addr), 32'(addr));
  endtask

  task automatic expect_head(input string tag, input logic valid, input logic [7:0] pc);
    check_output({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(valid));
    if (valid) begin
      check_output({tag, ".instr_pc"}, 32'(bus.instr_pc), 32'(pc));
      check_output({tag, ".instr_data"}, 32'(bus.instr_data), 32'(mem_word(pc)));
    end
  endtask

  task automatic expect_occ(input string tag, input logic [2:0] occ);
    check_output({tag, ".occupancy"}, 32'(bus.occupancy), 32'(occ));
  endtask

  initial begin
    reset              = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;

    //                rst rdy rdr rpc    req addr   val pc     occ
    // Reset release with a ready consumer: one instruction per cycle from N+2.
    vecs.push_back(row(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 3'd0));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 3'd0));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h01, 0, 8'h00, 3'd0));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h02, 1, 8'h00, 3'd1));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h03, 1, 8'h01, 3'd1));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h04, 1, 8'h02, 3'd1));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h05, 1, 8'h03, 3'd1));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h06, 1, 8'h04, 3'd1));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h07, 1, 8'h05, 3'd1));
    // Reset again, then stall the consumer for 10 cycles: exactly 4 requests, FIFO fills to 4.
    vecs.push_back(row(1, 0, 0, 8'h00, 0, 8'h00, 1, 8'h06, 3'd1));
    vecs.push_back(row(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 3'd0));
    vecs.push_back(row(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 3'd0));
    vecs.push_back(row(0, 0, 0, 8'h00, 1, 8'h01, 0, 8'h00, 3'd0));
    vecs.push_back(row(0, 0, 0, 8'h00, 1, 8'h02, 1, 8'h00, 3'd1));
    vecs.push_back(row(0, 0, 0, 8'h00, 1, 8'h03, 1, 8'h00, 3'd2));
    vecs.push_back(row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 3'd3));
    vecs.push_back(row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 3'd4));
    vecs.push_back(row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 3'd4));
    vecs.push_back(row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 3'd4));
    vecs.push_back(row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 3'd4));
    vecs.push_back(row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 3'd4));
    // Release: words drain in order while fetching resumes.
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h04, 1, 8'h00, 3'd4));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h05, 1, 8'h01, 3'd3));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h06, 1, 8'h02, 3'd3));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h07, 1, 8'h03, 3'd3));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h08, 1, 8'h04, 3'd3));
    vecs.push_back(row(0, 1, 0, 8'h00, 1, 8'h09, 1, 8'h05, 3'd3));

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      apply_stimulus(vecs[i].rst, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
      expect_req(tag, vecs[i].req, vecs[i].addr);
      expect_head(tag, vecs[i].valid, vecs[i].pc);
      expect_occ(tag, vecs[i].occ);
    end

    // Redirect to 0x40 with 3 words queued and one fetch in flight; nothing stale may surface.
    apply_stimulus(0, 0, 1, 8'h40);
    expect_req("redir40.R", 1'b0, 8'h00);
    expect_head("redir40.R", 1'b1, 8'h06);
    expect_occ("redir40.R", 3'd3);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_req("redir40.R1", 1'b1, 8'h40);
    expect_head("redir40.R1", 1'b0, 8'h00);
    expect_occ("redir40.R1", 3'd0);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_req("redir40.R2", 1'b1, 8'h41);
    expect_head("redir40.R2", 1'b0, 8'h00);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_head("redir40.R3", 1'b1, 8'h40);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_head("redir40.R4", 1'b1, 8'h41);

    // Redirect near the top of the address space: PC wraps 0xFF -> 0x00.
    apply_stimulus(0, 1, 1, 8'hFE);
    expect_req("wrap.R", 1'b0, 8'h00);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_req("wrap.R1", 1'b1, 8'hFE);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_req("wrap.R2", 1'b1, 8'hFF);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_req("wrap.R3", 1'b1, 8'h00);
    expect_head("wrap.R3", 1'b1, 8'hFE);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_head("wrap.R4", 1'b1, 8'hFF);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_head("wrap.R5", 1'b1, 8'h00);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_head("wrap.R6", 1'b1, 8'h01);

    // Mid-operation reset with 2 queued words and a fetch in flight.
    apply_stimulus(0, 0, 0, 8'h00);
    expect_req("rst.S1", 1'b1, 8'h04);
    expect_head("rst.S1", 1'b1, 8'h02);
    apply_stimulus(1, 0, 0, 8'h00);
    expect_occ("rst.S2", 3'd2);
    expect_req("rst.S2", 1'b0, 8'h00);
    apply_stimulus(0, 0, 0, 8'h00);
    expect_occ("rst.S3", 3'd0);
    expect_head("rst.S3", 1'b0, 8'h00);
    expect_req("rst.S3", 1'b1, 8'h00);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_head("rst.S4", 1'b0, 8'h00);
    expect_req("rst.S4", 1'b1, 8'h01);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_head("rst.S5", 1'b1, 8'h00);

    // Redirect and pop in the same cycle: the popped word is gone and the count does not underflow.
    apply_stimulus(0, 1, 1, 8'h80);
    expect_head("pop.T1", 1'b1, 8'h01);
    expect_req("pop.T1", 1'b0, 8'h00);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_occ("pop.T2", 3'd0);
    expect_head("pop.T2", 1'b0, 8'h00);
    expect_req("pop.T2", 1'b1, 8'h80);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_head("pop.T3", 1'b0, 8'h00);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_head("pop.T4", 1'b1, 8'h80);

    // Back-to-back redirects: the second target wins.
    apply_stimulus(0, 1, 1, 8'h10);
    expect_req("b2b.T5", 1'b0, 8'h00);
    apply_stimulus(0, 1, 1, 8'h20);
    expect_req("b2b.T6", 1'b0, 8'h00);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_req("b2b.T7", 1'b1, 8'h20);
    expect_occ("b2b.T7", 3'd0);
    expect_head("b2b.T7", 1'b0, 8'h00);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_head("b2b.T8", 1'b0, 8'h00);
    apply_stimulus(0, 1, 0, 8'h00);
    expect_head("b2b.T9", 1'b1, 8'h20);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end
endmodule
